// File: rtl/alu_pkg.sv
// Shared op-code constants, controller state encoding and reserved-op predicate
// for the ALU controller and the ALU it drives.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_NOT_A = 4'd3;
  localparam logic [3:0] OP_SHR_A = 4'd4;
  localparam logic [3:0] OP_SHL_A = 4'd5;
  localparam logic [3:0] OP_SHR_B = 4'd6;
  localparam logic [3:0] OP_SHL_B = 4'd7;
  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_SUB   = 4'd9;
  localparam logic [3:0] OP_ASR_A = 4'd10;
  localparam logic [3:0] OP_ASL_A = 4'd11;
  localparam logic [3:0] OP_ASR_B = 4'd12;
  localparam logic [3:0] OP_ASL_B = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Codes 14 and 15 are reserved.
  function automatic logic is_reserved(input logic [3:0] op);
    return op >= 4'd14;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU: single-bit shifts, add/sub with carry (borrow on SUB)
// and signed overflow, plus {N,Z,V,C} flags.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [3:0]   op,
  output logic [N-1:0] y,
  output logic         flag_n,
  output logic         flag_z,
  output logic         flag_v,
  output logic         flag_c
);

  logic [N-1:0] res;
  logic         carry;
  logic         ovf;

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_AND:   res = a & b;
      OP_OR:    res = a | b;
      OP_XOR:   res = a ^ b;
      OP_NOT_A: res = ~a;
      OP_SHR_A: begin res = {1'b0, a[N-1:1]}; carry = a[0]; end
      OP_SHL_A: begin res = {a[N-2:0], 1'b0}; carry = a[N-1]; end
      OP_SHR_B: begin res = {1'b0, b[N-1:1]}; carry = b[0]; end
      OP_SHL_B: begin res = {b[N-2:0], 1'b0}; carry = b[N-1]; end
      OP_ADD: begin
        {carry, res} = {1'b0, a} + {1'b0, b};
        ovf = (a[N-1] == b[N-1]) && (res[N-1] != a[N-1]);
      end
      // carry reports a borrow (a < b unsigned)
      OP_SUB: begin
        {carry, res} = {1'b0, a} - {1'b0, b};
        ovf = (a[N-1] != b[N-1]) && (res[N-1] != a[N-1]);
      end
      OP_ASR_A: begin res = {a[N-1], a[N-1:1]}; carry = a[0]; end
      OP_ASL_A: begin
        res   = {a[N-2:0], 1'b0};
        carry = a[N-1];
        ovf   = a[N-1] ^ a[N-2];
      end
      OP_ASR_B: begin res = {b[N-1], b[N-1:1]}; carry = b[0]; end
      OP_ASL_B: begin
        res   = {b[N-2:0], 1'b0};
        carry = b[N-1];
        ovf   = b[N-1] ^ b[N-2];
      end
      default: res = '0;
    endcase
  end

  assign y      = res;
  assign flag_n = res[N-1];
  assign flag_z = (res == '0);
  assign flag_v = ovf;
  assign flag_c = carry;

endmodule

// File: rtl/controlador_alu.sv
// Command/response controller around an external ALU: registers the command,
// waits one EXEC cycle, captures the result and holds it until consumed.
module controlador_alu
  import alu_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  output logic [N-1:0] alu_operador1,
  output logic [N-1:0] alu_operador2,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_resultado,
  input  logic         alu_flagNegativo,
  input  logic         alu_flagCero,
  input  logic         alu_flagOverflow,
  input  logic         alu_flagCarry,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_resultado,
  output logic [3:0]   rsp_flags,
  output logic         rsp_error,
  output logic [3:0]   flags_sticky,
  input  logic         clear_sticky,
  output logic [15:0]  op_count
);

  state_t     state, state_next;
  logic       accept;
  logic       capture;
  logic [3:0] alu_flags;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign capture   = (state == ST_EXEC);
  assign alu_flags = {alu_flagNegativo, alu_flagCero, alu_flagOverflow, alu_flagCarry};
  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_next = is_reserved(cmd_op) ? ST_RESP : ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_operador1 <= '0;
      alu_operador2 <= '0;
      alu_control   <= '0;
      rsp_resultado <= '0;
      rsp_flags     <= '0;
      rsp_error     <= 1'b0;
      flags_sticky  <= '0;
      op_count      <= '0;
    end else begin
      // Reserved ops go straight to RESP and leave the ALU inputs untouched.
      if (accept && is_reserved(cmd_op)) begin
        rsp_resultado <= '0;
        rsp_flags     <= '0;
        rsp_error     <= 1'b1;
      end else if (accept) begin
        alu_control   <= cmd_op;
        alu_operador1 <= cmd_a;
        alu_operador2 <= cmd_b;
      end

      if (capture) begin
        rsp_resultado <= alu_resultado;
        rsp_flags     <= alu_flags;
        rsp_error     <= 1'b0;
        op_count      <= op_count + 16'd1;
        flags_sticky  <= clear_sticky ? alu_flags : (flags_sticky | alu_flags);
      end else if (clear_sticky) begin
        flags_sticky  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_controlador_alu.sv
// Randomized self-checking bench for controlador_alu driving the team ALU,
// compared against an arithmetic reference model of the command/response behaviour.
module tb_controlador_alu;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = '0;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic [W-1:0] alu_operador1, alu_operador2, alu_resultado;
  logic [3:0]   alu_control;
  logic         alu_flagNegativo, alu_flagCero, alu_flagOverflow, alu_flagCarry;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_resultado;
  logic [3:0]   rsp_flags;
  logic         rsp_error;
  logic [3:0]   flags_sticky;
  logic         clear_sticky = 1'b0;
  logic [15:0]  op_count;

  int errors = 0;
  int checks = 0;

  int sticky_m = 0;
  int count_m  = 0;
  int last_op  = 0;
  int last_a   = 0;
  int last_b   = 0;

  always #5 clk = ~clk;

  controlador_alu #(.N(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_operador1(alu_operador1), .alu_operador2(alu_operador2),
    .alu_control(alu_control), .alu_resultado(alu_resultado),
    .alu_flagNegativo(alu_flagNegativo), .alu_flagCero(alu_flagCero),
    .alu_flagOverflow(alu_flagOverflow), .alu_flagCarry(alu_flagCarry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resultado(rsp_resultado), .rsp_flags(rsp_flags), .rsp_error(rsp_error),
    .flags_sticky(flags_sticky), .clear_sticky(clear_sticky), .op_count(op_count)
  );

  alu #(.N(W)) u_alu (
    .a(alu_operador1), .b(alu_operador2), .op(alu_control), .y(alu_resultado),
    .flag_n(alu_flagNegativo), .flag_z(alu_flagCero),
    .flag_v(alu_flagOverflow), .flag_c(alu_flagCarry)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference ALU in plain integer arithmetic; returns result and {N,Z,V,C}.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int res, output int fl);
    int r, c, v, s;
    c = 0; v = 0; r = 0;
    case (op)
      0:  r = a & b;
      1:  r = a | b;
      2:  r = a ^ b;
      3:  r = 255 - a;
      4:  begin r = a / 2; c = a % 2; end
      5:  begin r = (a * 2) % 256; c = (a >= 128); end
      6:  begin r = b / 2; c = b % 2; end
      7:  begin r = (b * 2) % 256; c = (b >= 128); end
      8:  begin
            r = a + b; c = (r > 255); r = r % 256;
            s = sgn(a) + sgn(b); v = (s > 127 || s < -128);
          end
      9:  begin
            c = (a < b); r = (a - b + 256) % 256;
            s = sgn(a) - sgn(b); v = (s > 127 || s < -128);
          end
      10: begin r = a / 2 + ((a >= 128) ? 128 : 0); c = a % 2; end
      11: begin
            r = (a * 2) % 256; c = (a >= 128);
            s = sgn(a) * 2; v = (s > 127 || s < -128);
          end
      12: begin r = b / 2 + ((b >= 128) ? 128 : 0); c = b % 2; end
      13: begin
            r = (b * 2) % 256; c = (b >= 128);
            s = sgn(b) * 2; v = (s > 127 || s < -128);
          end
      default: r = 0;
    endcase
    res = r;
    fl  = (op >= 14) ? 0 : ((r >= 128) * 8 + (r == 0) * 4 + v * 2 + c);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_alu"}, {alu_operador1, alu_operador2, alu_control}, 0);
    check({tag, "_rsp"}, {rsp_resultado, rsp_flags, rsp_error}, 0);
    check({tag, "_sticky"}, flags_sticky, 0);
    check({tag, "_count"}, op_count, 0);
  endtask

  // One full transaction; called with the bench at a negedge in IDLE.
  task automatic run_op(input int op, input int a, input int b, input int hold, input bit clr);
    int res, fl, lat, exp_lat;
    bit rsvd;
    rsvd = (op >= 14);
    ref_op(op, a, b, res, fl);
    exp_lat = rsvd ? 1 : 2;
    check("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 4'(op); cmd_a = 8'(a); cmd_b = 8'(b);
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom);
    lat = 1;
    if (!rsvd) begin
      check("exec_ready", cmd_ready, 0);
      check("exec_alu", {alu_control, alu_operador1, alu_operador2}, {4'(op), 8'(a), 8'(b)});
      last_op = op; last_a = a; last_b = b;
      clear_sticky = clr;
      sticky_m = clr ? fl : (sticky_m | fl);
      count_m  = (count_m + 1) % 65536;
    end
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); @(negedge clk);
      clear_sticky = 1'b0;
      lat++;
    end
    clear_sticky = 1'b0;
    check("latency", lat, exp_lat);
    check("rsp_result", rsp_resultado, res);
    check("rsp_flags", rsp_flags, fl);
    check("rsp_error", rsp_error, rsvd);
    check("sticky", flags_sticky, sticky_m);
    check("op_count", op_count, count_m);
    check("alu_retained", {alu_control, alu_operador1, alu_operador2},
          {4'(last_op), 8'(last_a), 8'(last_b)});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_ready", cmd_ready, 0);
      check("hold_rsp", {rsp_resultado, rsp_flags, rsp_error}, {8'(res), 4'(fl), rsvd});
    end
    // A command offered across the release edge must not be taken.
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_op = 4'($urandom_range(0, 13));
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    check("release_idle", {cmd_ready, rsp_valid}, 2'b10);
  endtask

  task automatic idle_clear();
    clear_sticky = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_sticky = 1'b0;
    sticky_m = 0;
    check("idle_clear", flags_sticky, 0);
  endtask

  function automatic int pick_operand();
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: return 0;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  initial begin
    #2;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_reset");

    run_op(8, 8'hFF, 8'h01, 0, 1'b0);
    check("add_zc", {rsp_resultado, rsp_flags}, {8'h00, 4'b0101});
    check("add_count", op_count, 1);
    run_op(2, 8'hF0, 8'h3C, 0, 1'b0);
    check("xor_result", {rsp_resultado, rsp_flags[3:2], rsp_error}, {8'hCC, 2'b10, 1'b0});
    run_op(14, 8'h12, 8'h34, 1, 1'b0);
    check("rsvd_ctl", alu_control, 2);
    run_op(15, 8'hAA, 8'h55, 0, 1'b0);
    run_op(9, 8'h10, 8'h20, 5, 1'b0);
    run_op(8, 8'hFF, 8'h01, 0, 1'b0);
    run_op(0, 8'h80, 8'h80, 0, 1'b1);
    check("sticky_clear_capture", flags_sticky, 4'b1000);
    idle_clear();

    // Reset while in EXEC drops the in-flight op.
    cmd_valid = 1'b1; cmd_op = 4'd8; cmd_a = 8'h7F; cmd_b = 8'h01;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_exec", cmd_ready, 0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_exec");
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    sticky_m = 0; count_m = 0; last_op = 0; last_a = 0; last_b = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("no_rsp_after_rst", {rsp_valid, cmd_ready}, 2'b01);
    end
    check("count_after_rst", op_count, 0);

    for (int i = 0; i < 150; i++) begin
      run_op($urandom_range(0, 15), pick_operand(), pick_operand(),
             $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 15) == 0) idle_clear();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
